// File: rtl/centroid_pkg.sv
// Shared widths, FSM encoding and coordinate saturation for the ball centroid block.
// Combinational helpers only.
package centroid_pkg;

    localparam int SUM_W      = 29;
    localparam int CNT_W      = 19;
    localparam int COORD_W    = 10;
    localparam int DIV_CYCLES = 29;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {
        ACCUM,
        LATCH,
        DIV_X,
        DIV_Y,
        OUT
    } state_t;

    function automatic logic [COORD_W-1:0] sat_coord(input logic [SUM_W-1:0] q, input int lim);
        if (q > SUM_W'(lim - 1)) begin
            return COORD_W'(lim - 1);
        end
        return q[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/centroid_div.sv
// Serial restoring divider, one quotient bit per cycle, shared between x and y.
// Latency: DIV_CYCLES cycles after start; done flags the final iteration cycle, with quotient valid in it.
// No backpressure: a start while running restarts the divider.
module centroid_div
    import centroid_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    logic [SUM_W-1:0]     quo;
    logic [CNT_W-1:0]     rem;
    logic [CNT_W-1:0]     dvs;
    logic [DIV_CNT_W-1:0] cnt;

    logic [CNT_W:0]       rem_sh;
    logic                 ge;
    logic [CNT_W-1:0]     sub;
    logic [CNT_W-1:0]     rem_nxt;
    logic [SUM_W-1:0]     quo_nxt;

    // When the trial subtraction succeeds the true difference is below dvs, so the low bits suffice.
    always_comb begin
        rem_sh  = {rem, quo[SUM_W-1]};
        ge      = (rem_sh >= {1'b0, dvs});
        sub     = rem_sh[CNT_W-1:0] - dvs;
        rem_nxt = ge ? sub : rem_sh[CNT_W-1:0];
        quo_nxt = {quo[SUM_W-2:0], ge};
    end

    assign done     = (cnt == DIV_CNT_W'(1));
    assign quotient = quo_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
            cnt <= DIV_CNT_W'(DIV_CYCLES);
        end else if (cnt != '0) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt - DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/ball_centroid_calc.sv
// Per-frame centroid of hit pixels; optional bounding box with CENTROID_BBOX_EN.
// Latency: coor_valid_flag rises 60 cycles after the frame-end cycle.
// No backpressure: pixels always accepted; a frame end while busy is dropped.
module ball_centroid_calc
    import centroid_pkg::*;
#(
    parameter int H_ACT      = 800,
    parameter int V_ACT      = 480,
    parameter int MIN_PIXELS = 64,
    parameter int VALID_HOLD = 4,
    parameter bit VS_POL     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               pixel_de,
    input  logic [9:0]         pixel_xpos,
    input  logic [9:0]         pixel_ypos,
    input  logic               hit,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               coor_valid_flag,
`ifdef CENTROID_BBOX_EN
    output logic [COORD_W-1:0] bbox_xmin,
    output logic [COORD_W-1:0] bbox_xmax,
    output logic [COORD_W-1:0] bbox_ymin,
    output logic [COORD_W-1:0] bbox_ymax,
`endif
    output logic               busy
);

    localparam int HOLD_W = (VALID_HOLD > 1) ? $clog2(VALID_HOLD) : 1;

    state_t             state;
    state_t             state_nxt;
    logic               vsync_r;
    logic               frame_end;
    logic               accept;
    logic               pix_hit;

    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
    logic [CNT_W-1:0]   cnt;
    logic [SUM_W-1:0]   sum_x_snap;
    logic [SUM_W-1:0]   sum_y_snap;
    logic [CNT_W-1:0]   cnt_snap;
    logic [SUM_W-1:0]   quo_x;

    logic               div_start;
    logic [SUM_W-1:0]   div_dividend;
    logic               div_done;
    logic [SUM_W-1:0]   div_quotient;
    logic               publish;

    logic [HOLD_W-1:0]  hold;
    logic               restart;

    assign pix_hit   = pixel_de & hit;
    assign frame_end = (vsync == VS_POL) && (vsync_r != VS_POL);
    assign busy      = (state == LATCH) || (state == DIV_X) || (state == DIV_Y);
    assign accept    = frame_end & ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= ~VS_POL;
        end else begin
            vsync_r <= vsync;
        end
    end

    // A hit in the frame-end cycle belongs to the frame that is starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (frame_end) begin
            sum_x <= pix_hit ? SUM_W'(pixel_xpos) : '0;
            sum_y <= pix_hit ? SUM_W'(pixel_ypos) : '0;
            cnt   <= pix_hit ? CNT_W'(1) : '0;
        end else if (pix_hit) begin
            sum_x <= sum_x + SUM_W'(pixel_xpos);
            sum_y <= sum_y + SUM_W'(pixel_ypos);
            cnt   <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x_snap <= '0;
            sum_y_snap <= '0;
            cnt_snap   <= '0;
        end else if (accept) begin
            sum_x_snap <= sum_x;
            sum_y_snap <= sum_y;
            cnt_snap   <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        div_dividend = sum_x_snap;
        publish      = 1'b0;
        case (state)
            ACCUM: begin
                if (accept) state_nxt = LATCH;
            end
            LATCH: begin
                if (cnt_snap < CNT_W'(MIN_PIXELS)) begin
                    state_nxt = ACCUM;
                end else begin
                    div_start = 1'b1;
                    state_nxt = DIV_X;
                end
            end
            DIV_X: begin
                if (div_done) begin
                    div_start    = 1'b1;
                    div_dividend = sum_y_snap;
                    state_nxt    = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_done) begin
                    publish   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                state_nxt = accept ? LATCH : ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    centroid_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cnt_snap),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_x <= '0;
        end else if ((state == DIV_X) && div_done) begin
            quo_x <= div_quotient;
        end
    end

    // Outputs load on the last DIV_Y edge so they are visible throughout the OUT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= COORD_W'(H_ACT / 2);
            y_pos <= COORD_W'(V_ACT / 2);
        end else if (publish) begin
            x_pos <= sat_coord(quo_x, H_ACT);
            y_pos <= sat_coord(div_quotient, V_ACT);
        end
    end

    // A result arriving while the flag is still high forces a one-cycle low so each result has its own edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coor_valid_flag <= 1'b0;
            hold            <= '0;
            restart         <= 1'b0;
        end else if (publish) begin
            if (coor_valid_flag) begin
                coor_valid_flag <= 1'b0;
                restart         <= 1'b1;
            end else begin
                coor_valid_flag <= 1'b1;
                hold            <= HOLD_W'(VALID_HOLD - 1);
            end
        end else if (restart) begin
            coor_valid_flag <= 1'b1;
            hold            <= HOLD_W'(VALID_HOLD - 1);
            restart         <= 1'b0;
        end else if (coor_valid_flag) begin
            if (hold == '0) begin
                coor_valid_flag <= 1'b0;
            end else begin
                hold <= hold - HOLD_W'(1);
            end
        end
    end

`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] run_xmin, run_xmax, run_ymin, run_ymax;
    logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_xmin <= '1;
            run_xmax <= '0;
            run_ymin <= '1;
            run_ymax <= '0;
        end else if (frame_end) begin
            run_xmin <= pix_hit ? pixel_xpos : '1;
            run_xmax <= pix_hit ? pixel_xpos : '0;
            run_ymin <= pix_hit ? pixel_ypos : '1;
            run_ymax <= pix_hit ? pixel_ypos : '0;
        end else if (pix_hit) begin
            if (pixel_xpos < run_xmin) run_xmin <= pixel_xpos;
            if (pixel_xpos > run_xmax) run_xmax <= pixel_xpos;
            if (pixel_ypos < run_ymin) run_ymin <= pixel_ypos;
            if (pixel_ypos > run_ymax) run_ymax <= pixel_ypos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_xmin <= '0;
            snap_xmax <= '0;
            snap_ymin <= '0;
            snap_ymax <= '0;
        end else if (accept) begin
            snap_xmin <= run_xmin;
            snap_xmax <= run_xmax;
            snap_ymin <= run_ymin;
            snap_ymax <= run_ymax;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbox_xmin <= '0;
            bbox_xmax <= '0;
            bbox_ymin <= '0;
            bbox_ymax <= '0;
        end else if (publish) begin
            bbox_xmin <= snap_xmin;
            bbox_xmax <= snap_xmax;
            bbox_ymin <= snap_ymin;
            bbox_ymax <= snap_ymax;
        end
    end
`endif

endmodule

// File: tb/tb_ball_centroid_calc.sv
// Bench for ball_centroid_calc: directed frames plus random frames against an arithmetic frame model.
module tb_ball_centroid_calc;

    localparam int H_ACT   = 800;
    localparam int V_ACT   = 480;
    localparam int MIN_PIX = 64;
    localparam int HOLD    = 4;
    localparam int LAT     = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       pixel_de = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] pixel_xpos = '0;
    logic [9:0] pixel_ypos = '0;
    logic [9:0] x_pos, y_pos;
    logic       coor_valid_flag, busy;
`ifdef CENTROID_BBOX_EN
    logic [9:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`endif

    ball_centroid_calc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vsync           (vsync),
        .pixel_de        (pixel_de),
        .pixel_xpos      (pixel_xpos),
        .pixel_ypos      (pixel_ypos),
        .hit             (hit),
        .x_pos           (x_pos),
        .y_pos           (y_pos),
        .coor_valid_flag (coor_valid_flag),
`ifdef CENTROID_BBOX_EN
        .bbox_xmin       (bbox_xmin),
        .bbox_xmax       (bbox_xmax),
        .bbox_ymin       (bbox_ymin),
        .bbox_ymax       (bbox_ymax),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Frame model: running sums of the current frame and the values the DUT should be showing.
    longint m_sx, m_sy, m_cnt;
    int m_xmin, m_xmax, m_ymin, m_ymax;
    int m_busy_end = -1000;
    int exp_x = 400, exp_y = 240;
    int exp_bx0 = 0, exp_bx1 = 0, exp_by0 = 0, exp_by1 = 0;
    bit exp_report = 1'b0;

    int rise_q[$];
    int run_q[$];
    int run_len = 0;
    bit flag_prev = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (coor_valid_flag === 1'b1) begin
                if (!flag_prev) rise_q.push_back(cyc);
                run_len++;
            end else if (flag_prev) begin
                run_q.push_back(run_len);
                run_len = 0;
            end
            flag_prev = (coor_valid_flag === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
    endtask

    task automatic model_hit(input int x, input int y);
        m_sx += x; m_sy += y; m_cnt++;
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
    endtask

    task automatic drive_pixel(input int x, input int y, input bit de, input bit h);
        pixel_de = de; hit = h;
        pixel_xpos = x[9:0]; pixel_ypos = y[9:0];
        if (de && h) model_hit(x, y);
        tick();
        pixel_de = 0; hit = 0;
    endtask

    task automatic frame_end(input bit edge_hit, input int hx, input int hy, output int fe);
        fe = cyc;
        vsync = 1'b1;
        if (fe > m_busy_end) begin
            if (m_cnt >= MIN_PIX) begin
                exp_report = 1'b1;
                exp_x = int'(m_sx / m_cnt);
                exp_y = int'(m_sy / m_cnt);
                if (exp_x > H_ACT - 1) exp_x = H_ACT - 1;
                if (exp_y > V_ACT - 1) exp_y = V_ACT - 1;
                exp_bx0 = m_xmin; exp_bx1 = m_xmax; exp_by0 = m_ymin; exp_by1 = m_ymax;
                m_busy_end = fe + LAT - 1;
            end else begin
                exp_report = 1'b0;
                m_busy_end = fe + 1;
            end
        end
        model_clear();
        if (edge_hit) begin
            pixel_de = 1; hit = 1;
            pixel_xpos = hx[9:0]; pixel_ypos = hy[9:0];
            model_hit(hx, hy);
        end
        tick();
        pixel_de = 0; hit = 0;
        tick();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        model_clear();
        m_busy_end = -1000;
        exp_x = 400; exp_y = 240;
        exp_bx0 = 0; exp_bx1 = 0; exp_by0 = 0; exp_by1 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; vsync = 0;
        model_reset();
        repeat (3) tick();
        checks++; if (x_pos !== 10'd400) begin failures++; $display("FAIL reset_x_pos: got %0d required 400", x_pos); end
        checks++; if (y_pos !== 10'd240) begin failures++; $display("FAIL reset_y_pos: got %0d required 240", y_pos); end
        checks++; if (coor_valid_flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b required 0", coor_valid_flag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef CENTROID_BBOX_EN
        checks++; if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 40'd0) begin failures++; $display("FAIL reset_bbox: got %0d/%0d/%0d/%0d required 0", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax); end
`endif
        rst_n = 1;
        repeat (2) tick();
    endtask

    task automatic test_min_pixels();
        int fe;
        int counts[2] = '{50, 63};
        foreach (counts[k]) begin
            rise_q.delete();
            for (int i = 0; i < counts[k]; i++) drive_pixel($urandom_range(0, 799), $urandom_range(0, 479), 1, 1);
            frame_end(0, 0, 0, fe);
            wait_until(fe + 70);
            checks++; if (rise_q.size() != 0) begin failures++; $display("FAIL min_pixels_%0d_edges: got %0d required 0", counts[k], rise_q.size()); end
            checks++; if (x_pos !== exp_x[9:0]) begin failures++; $display("FAIL min_pixels_%0d_x: got %0d required %0d", counts[k], x_pos, exp_x); end
            checks++; if (y_pos !== exp_y[9:0]) begin failures++; $display("FAIL min_pixels_%0d_y: got %0d required %0d", counts[k], y_pos, exp_y); end
        end
    endtask

    task automatic test_square();
        int fe;
        rise_q.delete(); run_q.delete();
        for (int y = 235; y <= 244; y++) begin
            for (int x = 395; x <= 404; x++) drive_pixel(x, y, 1, 1);
            drive_pixel(10, y, 1, 0);
            drive_pixel(700, y, 0, 1);
        end
        frame_end(0, 0, 0, fe);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL square_busy_early: got %b required 1", busy); end
        wait_until(fe + LAT - 1);
        checks++; if (busy !== 1'b1 || coor_valid_flag !== 1'b0) begin failures++; $display("FAIL square_last_div_cycle: busy=%b flag=%b required busy=1 flag=0", busy, coor_valid_flag); end
        tick();
        checks++; if (coor_valid_flag !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL square_out_cycle: flag=%b busy=%b required flag=1 busy=0", coor_valid_flag, busy); end
        checks++; if (x_pos !== exp_x[9:0]) begin failures++; $display("FAIL square_x: got %0d required %0d", x_pos, exp_x); end
        checks++; if (y_pos !== exp_y[9:0]) begin failures++; $display("FAIL square_y: got %0d required %0d", y_pos, exp_y); end
`ifdef CENTROID_BBOX_EN
        checks++; if (bbox_xmin !== exp_bx0[9:0] || bbox_xmax !== exp_bx1[9:0] || bbox_ymin !== exp_by0[9:0] || bbox_ymax !== exp_by1[9:0]) begin
            failures++; $display("FAIL square_bbox: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, exp_bx0, exp_bx1, exp_by0, exp_by1);
        end
`endif
        wait_until(fe + LAT + 10);
        checks++; if (rise_q.size() != 1 || (rise_q.size() > 0 && rise_q[0] != fe + LAT)) begin failures++; $display("FAIL square_latency: edges=%0d first=%0d required one edge at %0d", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, fe + LAT); end
        checks++; if (run_q.size() != 1 || (run_q.size() > 0 && run_q[0] != HOLD)) begin failures++; $display("FAIL square_hold: runs=%0d len=%0d required one run of %0d", run_q.size(), (run_q.size() > 0) ? run_q[0] : -1, HOLD); end
    endtask

    task automatic test_full_frame();
        int fe;
        rise_q.delete();
        for (int x = 0; x < H_ACT; x++) drive_pixel(x, 0, 1, 1);
        for (int x = 0; x < H_ACT; x++) drive_pixel(x, V_ACT - 1, 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + LAT + 5);
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL full_frame_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
        checks++; if (rise_q.size() != 1) begin failures++; $display("FAIL full_frame_edges: got %0d required 1", rise_q.size()); end
        rise_q.delete();
        for (int y = 0; y < V_ACT; y++) drive_pixel(H_ACT - 1, y, 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + LAT + 5);
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL column_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
        checks++; if (rise_q.size() != 1) begin failures++; $display("FAIL column_edges: got %0d required 1", rise_q.size()); end
    endtask

    task automatic test_saturation();
        int fe;
        for (int i = 0; i < MIN_PIX; i++) drive_pixel($urandom_range(800, 1023), $urandom_range(480, 1023), 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + LAT + 5);
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL saturation_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
    endtask

    task automatic test_back_to_back();
        int fe1, fe2, fe3, ax, ay;
        rise_q.delete();
        for (int i = 0; i < 80; i++) drive_pixel($urandom_range(0, 799), $urandom_range(0, 479), 1, 1);
        frame_end(0, 0, 0, fe1);
        ax = exp_x; ay = exp_y;
        for (int i = 0; i < 5; i++) drive_pixel(10, 10, 1, 1);
        wait_until(fe1 + 20);
        frame_end(1, 700, 400, fe2);
        for (int i = 0; i < 70; i++) drive_pixel(100, 50, 1, 1);
        wait_until(fe1 + LAT + 10);
        checks++; if (rise_q.size() != 1 || (rise_q.size() > 0 && rise_q[0] != fe1 + LAT)) begin failures++; $display("FAIL dropped_frame_edges: edges=%0d first=%0d required one edge at %0d", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, fe1 + LAT); end
        checks++; if (x_pos !== ax[9:0] || y_pos !== ay[9:0]) begin failures++; $display("FAIL dropped_frame_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, ax, ay); end
        frame_end(0, 0, 0, fe3);
        wait_until(fe3 + LAT + 5);
        checks++; if (rise_q.size() != 2) begin failures++; $display("FAIL next_frame_edges: got %0d required 2", rise_q.size()); end
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL next_frame_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
    endtask

    task automatic test_reset_mid();
        int fe;
        for (int i = 0; i < MIN_PIX; i++) drive_pixel(100, 50, 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + LAT + 5);
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL exact_min_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
        for (int i = 0; i < 100; i++) drive_pixel($urandom_range(500, 799), $urandom_range(300, 479), 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + 40);
        rst_n = 0;
        model_reset();
        #1;
        checks++; if (x_pos !== 10'd400 || y_pos !== 10'd240) begin failures++; $display("FAIL midreset_xy: got %0d/%0d required 400/240", x_pos, y_pos); end
        checks++; if (coor_valid_flag !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_ctl: flag=%b busy=%b required 0/0", coor_valid_flag, busy); end
        tick(); tick();
        rst_n = 1;
        tick();
        rise_q.delete();
        for (int i = 0; i < 80; i++) drive_pixel($urandom_range(0, 799), $urandom_range(0, 479), 1, 1);
        frame_end(0, 0, 0, fe);
        wait_until(fe + LAT + 5);
        checks++; if (rise_q.size() != 1 || (rise_q.size() > 0 && rise_q[0] != fe + LAT)) begin failures++; $display("FAIL after_reset_latency: edges=%0d first=%0d required one edge at %0d", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, fe + LAT); end
        checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL after_reset_xy: got %0d/%0d required %0d/%0d", x_pos, y_pos, exp_x, exp_y); end
    endtask

    task automatic test_random();
        int fe, n, x, y;
        for (int f = 0; f < 5; f++) begin
            rise_q.delete();
            n = $urandom_range(20, 150);
            for (int i = 0; i < n; i++) begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 479);
                if ($urandom_range(0, 3) == 0) drive_pixel($urandom_range(0, 799), $urandom_range(0, 479), 1, 0);
                if ($urandom_range(0, 4) == 0) drive_pixel(x, y, 0, 1);
                drive_pixel(x, y, 1, 1);
            end
            frame_end(bit'($urandom_range(0, 1)), $urandom_range(0, 799), $urandom_range(0, 479), fe);
            wait_until(fe + LAT + 6);
            checks++; if (rise_q.size() != (exp_report ? 1 : 0)) begin failures++; $display("FAIL random_%0d_edges: got %0d required %0d (hits=%0d)", f, rise_q.size(), exp_report ? 1 : 0, n); end
            if (exp_report && rise_q.size() > 0) begin
                checks++; if (rise_q[0] != fe + LAT) begin failures++; $display("FAIL random_%0d_latency: got %0d required %0d", f, rise_q[0] - fe, LAT); end
            end
            checks++; if (x_pos !== exp_x[9:0] || y_pos !== exp_y[9:0]) begin failures++; $display("FAIL random_%0d_xy: got %0d/%0d required %0d/%0d", f, x_pos, y_pos, exp_x, exp_y); end
`ifdef CENTROID_BBOX_EN
            checks++; if (bbox_xmin !== exp_bx0[9:0] || bbox_xmax !== exp_bx1[9:0] || bbox_ymin !== exp_by0[9:0] || bbox_ymax !== exp_by1[9:0]) begin
                failures++; $display("FAIL random_%0d_bbox: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", f, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, exp_bx0, exp_bx1, exp_by0, exp_by1);
            end
`endif
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_min_pixels();
        test_square();
        test_full_frame();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
